// File: rtl/sarray_mem_pkg.sv
// sarray_mem_pkg: shared widths, beat type and word-index helper for the sarray memory responder.
//   ADDR_W     byte-address width
//   DATA_W     load/store beat width
//   rsp_beat_t one read-response beat held in the response FIFO
//   word_idx   byte address -> word address (byte-offset bits dropped, not yet wrapped)
package sarray_mem_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 128;
  localparam int OFF_W = $clog2(DATA_W / 8);
  typedef struct packed {
    logic [DATA_W-1:0] data;
  } rsp_beat_t;
  function automatic logic [ADDR_W-1:0] word_idx(input logic [ADDR_W-1:0] addr);
    return addr >> OFF_W;
  endfunction
endpackage

// File: rtl/sarray_mem_responder_if.sv
// sarray_mem_responder_if: sarray load/store bus (AR read request, R read data, AW single-beat write).
//   ar_valid/ar_ready/ar_addr          read request
//   r_valid/r_ready/r_data             in-order read data
//   aw_valid/aw_ready/aw_addr/aw_data  full-word write, address and data in one beat
//   master modport: requester side, slave modport: memory side
interface sarray_mem_responder_if
  import sarray_mem_pkg::*;
();
  logic              ar_valid;
  logic              ar_ready;
  logic [ADDR_W-1:0] ar_addr;
  logic              r_valid;
  logic              r_ready;
  logic [DATA_W-1:0] r_data;
  logic              aw_valid;
  logic              aw_ready;
  logic [ADDR_W-1:0] aw_addr;
  logic [DATA_W-1:0] aw_data;
  modport master (
    output ar_valid, ar_addr, r_ready, aw_valid, aw_addr, aw_data,
    input  ar_ready, r_valid, r_data, aw_ready
  );
  modport slave (
    input  ar_valid, ar_addr, r_ready, aw_valid, aw_addr, aw_data,
    output ar_ready, r_valid, r_data, aw_ready
  );
endinterface

// File: rtl/sarray_mem_rsp_fifo.sv
// sarray_mem_rsp_fifo: synchronous FIFO of read-response beats with async active-high reset.
//   clk, rst     clock, asynchronous active-high reset
//   push, din    write one beat (ignored when full)
//   pop          remove head beat (ignored when empty)
//   dout         head beat; while empty it holds the last popped beat (zero after reset)
//   full, empty  occupancy flags
module sarray_mem_rsp_fifo
  import sarray_mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  rsp_beat_t din,
  input  logic      pop,
  output rsp_beat_t dout,
  output logic      full,
  output logic      empty
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  rsp_beat_t         buffer [DEPTH];
  rsp_beat_t         last;
  logic [PW-1:0]     wp, rp;
  logic [CW-1:0]     cnt;
  logic              do_push, do_pop;
  assign full    = cnt == CW'(DEPTH);
  assign empty   = cnt == '0;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = empty ? last : buffer[rp];
  always_ff @(posedge clk)
    if (do_push) buffer[wp] <= din;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp   <= '0;
      rp   <= '0;
      cnt  <= '0;
      last <= '0;
    end else begin
      if (do_push) wp <= wp == PW'(DEPTH - 1) ? '0 : wp + 1'b1;
      if (do_pop) rp <= rp == PW'(DEPTH - 1) ? '0 : rp + 1'b1;
      if (do_pop) last <= buffer[rp];
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/sarray_mem_responder.sv
// sarray_mem_responder: memory-side responder for the sarray load/store bus, backed by a word RAM.
//   clk   clock, rising edge
//   rst   asynchronous active-high reset (flushes read pipeline, FIFO and credits; RAM retained)
//   bus   sarray_mem_responder_if.slave: AR requests, in-order R beats, single-beat AW writes
// Parameters: MEM_DEPTH (RAM words, power of two), RD_LAT (AR accept -> earliest r_valid, >=1),
// MAX_OUTST (outstanding reads = FIFO depth, >=RD_LAT). Widths come from sarray_mem_pkg.
// Optional macro SARRAY_MEM_RAND_BP_EN: an 8-bit LFSR randomly gates ar_ready and aw_ready.
module sarray_mem_responder
  import sarray_mem_pkg::*;
#(
  parameter int MEM_DEPTH = 1024,
  parameter int RD_LAT    = 2,
  parameter int MAX_OUTST = 4
) (
  input logic                   clk,
  input logic                   rst,
  sarray_mem_responder_if.slave bus
);
  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int CW    = $clog2(MAX_OUTST + 1);
  logic [DATA_W-1:0] mem [MEM_DEPTH];
  logic [IDX_W-1:0]  ar_idx, aw_idx;
  logic [CW-1:0]     credits;
  logic              ar_acc, aw_acc, r_hs, push, full, empty, bp_ar, bp_aw;
  rsp_beat_t         push_beat, head;
`ifdef SARRAY_MEM_RAND_BP_EN
  logic [7:0] lfsr;
  always_ff @(posedge clk or posedge rst)
    if (rst) lfsr <= 8'hA5;
    else lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  assign bp_ar = lfsr[0];
  assign bp_aw = lfsr[1];
`else
  assign bp_ar = 1'b1;
  assign bp_aw = 1'b1;
`endif
  // Indices wrap silently to the RAM depth after dropping the byte offset.
  assign ar_idx       = IDX_W'(word_idx(bus.ar_addr));
  assign aw_idx       = IDX_W'(word_idx(bus.aw_addr));
  // ar_ready depends only on registered credits, so r_ready never reaches it combinationally.
  assign bus.ar_ready = (credits != '0) & bp_ar;
  assign bus.aw_ready = bp_aw;
  assign ar_acc       = bus.ar_valid & bus.ar_ready;
  assign aw_acc       = bus.aw_valid & bus.aw_ready;
  assign r_hs         = bus.r_valid & bus.r_ready;
  assign bus.r_valid  = ~empty;
  assign bus.r_data   = head.data;
  always_ff @(posedge clk)
    if (aw_acc) mem[aw_idx] <= bus.aw_data;
  // The RAM is sampled on the accept edge, before the same edge's write lands: read-first.
  if (RD_LAT == 1) begin : g_direct
    assign push           = ar_acc;
    assign push_beat.data = mem[ar_idx];
  end else begin : g_pipe
    logic [RD_LAT-2:0] pv;
    logic [DATA_W-1:0] pd [RD_LAT-1];
    always_ff @(posedge clk or posedge rst)
      if (rst) pv <= '0;
      else pv <= (RD_LAT-1)'({pv, ar_acc});
    always_ff @(posedge clk) begin
      pd[0] <= mem[ar_idx];
      for (int i = 1; i < RD_LAT - 1; i++) pd[i] <= pd[i-1];
    end
    assign push           = pv[RD_LAT-2];
    assign push_beat.data = pd[RD_LAT-2];
  end
  // Credits count free slots across pipeline and FIFO, so an accepted read always has room.
  always_ff @(posedge clk or posedge rst)
    if (rst) credits <= CW'(MAX_OUTST);
    else credits <= credits - CW'(ar_acc) + CW'(r_hs);
  sarray_mem_rsp_fifo #(.DEPTH(MAX_OUTST)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push & ~full),
    .din   (push_beat),
    .pop   (r_hs),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );
endmodule

// File: tb/tb_sarray_mem_responder.sv
// tb_sarray_mem_responder: directed self-checking bench for sarray_mem_responder.
module tb_sarray_mem_responder;
  localparam logic [127:0] W1 = {4{32'h1111_1111}};
  localparam logic [127:0] W2 = {4{32'h2222_2222}};
  localparam logic [127:0] WA = 128'hA;
  localparam logic [127:0] WB = 128'hB;
  localparam logic [127:0] WC = 128'hC;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_checks = 0;
  int n_fail = 0;
  sarray_mem_responder_if bus ();
  sarray_mem_responder #(.MEM_DEPTH(1024), .RD_LAT(2), .MAX_OUTST(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic get_beat(input string tag, input logic [127:0] exp);
    int k = 0;
    bus.r_ready = 1'b1;
    while (!bus.r_valid && k < 10) begin
      step;
      k++;
    end
    chk({tag, " valid"}, 128'(bus.r_valid), 128'd1);
    chk(tag, bus.r_data, exp);
    step;
    bus.r_ready = 1'b0;
  endtask
  task automatic write(input logic [31:0] addr, input logic [127:0] data);
    bus.aw_valid = 1'b1;
    bus.aw_addr  = addr;
    bus.aw_data  = data;
    step;
    bus.aw_valid = 1'b0;
  endtask
`ifdef SARRAY_MEM_RAND_BP_EN
  logic [127:0] model [8];
  logic [127:0] q[$];
`endif
  initial begin
    int acc, got, seen;
    bus.ar_valid = 1'b0;
    bus.ar_addr  = '0;
    bus.r_ready  = 1'b0;
    bus.aw_valid = 1'b0;
    bus.aw_addr  = '0;
    bus.aw_data  = '0;
    step;
    step;
    chk("reset r_valid", 128'(bus.r_valid), 128'd0);
    chk("reset r_data", bus.r_data, 128'd0);
    chk("reset ar_ready", 128'(bus.ar_ready), 128'd1);
`ifdef SARRAY_MEM_RAND_BP_EN
    chk("reset aw_ready", 128'(bus.aw_ready), 128'd0);
    rst = 1'b0;
    for (int w = 0; w < 8; w++) begin
      int k = 0;
      bus.aw_valid = 1'b1;
      bus.aw_addr  = 32'(w * 16);
      bus.aw_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
      while (!bus.aw_ready && k < 50) begin
        step;
        k++;
      end
      model[w] = bus.aw_data;
      step;
    end
    bus.aw_valid = 1'b0;
    for (int c = 0; c < 200; c++) begin
      bus.ar_valid = 1'($urandom_range(0, 1));
      bus.ar_addr  = 32'($urandom_range(0, 127));
      bus.aw_valid = 1'($urandom_range(0, 1));
      bus.aw_addr  = 32'($urandom_range(0, 127));
      bus.aw_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
      bus.r_ready  = 1'($urandom_range(0, 1));
      if (bus.r_valid && bus.r_ready) begin
        chk("t6 no extra beat", 128'(q.size() != 0), 128'd1);
        if (q.size() != 0) chk("t6 data", bus.r_data, q.pop_front());
      end
      if (bus.ar_valid && bus.ar_ready) q.push_back(model[bus.ar_addr[6:4]]);
      if (bus.aw_valid && bus.aw_ready) model[bus.aw_addr[6:4]] = bus.aw_data;
      step;
    end
    bus.ar_valid = 1'b0;
    bus.aw_valid = 1'b0;
    bus.r_ready  = 1'b1;
    for (int c = 0; c < 50 && q.size() != 0; c++) begin
      if (bus.r_valid) chk("t6 drain data", bus.r_data, q.pop_front());
      step;
    end
    chk("t6 all returned", 128'(q.size()), 128'd0);
    step;
    step;
    chk("t6 no duplicate", 128'(bus.r_valid), 128'd0);
`else
    chk("reset aw_ready", 128'(bus.aw_ready), 128'd1);
    rst = 1'b0;
    // 1: write then read, exact latency
    write(32'h0, W1);
    write(32'h10, W2);
    bus.ar_valid = 1'b1;
    bus.ar_addr  = 32'h0;
    step;
    chk("t1 no early valid", 128'(bus.r_valid), 128'd0);
    bus.ar_addr = 32'h10;
    step;
    chk("t1 valid at RD_LAT", 128'(bus.r_valid), 128'd1);
    chk("t1 beat0", bus.r_data, W1);
    bus.ar_valid = 1'b0;
    bus.r_ready  = 1'b1;
    step;
    chk("t1 beat1 valid", 128'(bus.r_valid), 128'd1);
    chk("t1 beat1", bus.r_data, W2);
    step;
    chk("t1 empty", 128'(bus.r_valid), 128'd0);
    chk("t1 data held", bus.r_data, W2);
    bus.r_ready = 1'b0;
    // 2: backpressure, four credits
    acc = 0;
    bus.ar_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.ar_addr = acc % 2 ? 32'h10 : 32'h0;
      if (bus.ar_ready) acc++;
      step;
    end
    chk("t2 accepted", 128'(acc), 128'd4);
    chk("t2 ar_ready low", 128'(bus.ar_ready), 128'd0);
    chk("t2 head", bus.r_data, W1);
    step;
    step;
    chk("t2 head valid held", 128'(bus.r_valid), 128'd1);
    chk("t2 head stable", bus.r_data, W1);
    bus.r_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 30 && got < 6; c++) begin
      bus.ar_valid = acc < 6;
      bus.ar_addr  = acc % 2 ? 32'h10 : 32'h0;
      if (bus.ar_valid && bus.ar_ready) acc++;
      if (bus.r_valid) begin
        chk($sformatf("t2 beat%0d", got), bus.r_data, got % 2 ? W2 : W1);
        got++;
      end
      step;
    end
    bus.ar_valid = 1'b0;
    chk("t2 beats", 128'(got), 128'd6);
    chk("t2 total accepted", 128'(acc), 128'd6);
    step;
    chk("t2 drained", 128'(bus.r_valid), 128'd0);
    bus.r_ready = 1'b0;
    // 3: same-cycle AR/AW to one word is read-first
    write(32'h20, WA);
    bus.aw_valid = 1'b1;
    bus.aw_addr  = 32'h20;
    bus.aw_data  = WB;
    bus.ar_valid = 1'b1;
    bus.ar_addr  = 32'h20;
    step;
    bus.aw_valid = 1'b0;
    step;
    bus.ar_valid = 1'b0;
    get_beat("t3 old", WA);
    get_beat("t3 new", WB);
    // 4: upper address bits wrap, byte offset ignored
    write(32'h4000, WC);
    bus.ar_valid = 1'b1;
    bus.ar_addr  = 32'h0;
    step;
    bus.ar_addr = 32'h7;
    step;
    bus.ar_valid = 1'b0;
    get_beat("t4 wrap", WC);
    get_beat("t4 offset", WC);
    // 5: reset with reads in flight
    bus.ar_valid = 1'b1;
    bus.ar_addr  = 32'h10;
    step;
    step;
    step;
    bus.ar_valid = 1'b0;
    chk("t5 pending", 128'(bus.r_valid), 128'd1);
    rst = 1'b1;
    #1;
    chk("t5 async drop", 128'(bus.r_valid), 128'd0);
    step;
    rst = 1'b0;
    chk("t5 ar_ready", 128'(bus.ar_ready), 128'd1);
    chk("t5 data cleared", bus.r_data, 128'd0);
    bus.r_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (bus.r_valid) seen++;
      step;
    end
    chk("t5 no stale beat", 128'(seen), 128'd0);
    bus.r_ready  = 1'b0;
    bus.ar_valid = 1'b1;
    bus.ar_addr  = 32'h10;
    step;
    bus.ar_valid = 1'b0;
    get_beat("t5 ram retained", W2);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
